// File: rtl/adder_txn_initiator.sv
// adder_txn_initiator: valid/ready initiator that drives a combinational adder,
// waits a fixed settle time, captures the sum and returns it with handshake counters.
module adder_txn_initiator #(
   parameter int DATA_W        = 4,
   parameter int SETTLE_CYCLES = 1,
   parameter int COUNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic [DATA_W-1:0] drv_a,
   output logic [DATA_W-1:0] drv_b,
   input  logic [DATA_W:0]   res_c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W:0]   out_sum,
   output logic              out_carry,
   output logic [COUNT_W-1:0] txn_count,
   output logic [COUNT_W-1:0] carry_count
);
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic accept, settle_done, handshake;

   generate
      if (SETTLE_CYCLES < 1) begin : g_bad_settle
         $error("SETTLE_CYCLES must be at least 1");
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end

   // A response handshake with a waiting request re-enters SETTLE directly.
   always_comb begin
      accept      = in_valid && in_ready;
      handshake   = out_valid && out_ready;
      settle_done = state == SETTLE && cnt == CNT_W'(1);
      state_nxt   = accept ? SETTLE : settle_done ? RESP : handshake ? IDLE : state;
   end

   always_comb begin
      in_ready  = state == IDLE || (state == RESP && out_ready);
      out_valid = state == RESP;
   end

   assign out_carry = out_sum[DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drv_a       <= '0;
         drv_b       <= '0;
         cnt         <= '0;
         out_sum     <= '0;
         txn_count   <= '0;
         carry_count <= '0;
      end else begin
         if (accept) begin
            drv_a <= in_a;
            drv_b <= in_b;
         end
         cnt <= accept ? CNT_W'(SETTLE_CYCLES) : (state == SETTLE) ? cnt - CNT_W'(1) : cnt;
         if (settle_done) out_sum <= res_c;
         if (handshake) begin
            txn_count   <= txn_count + COUNT_W'(1);
            carry_count <= carry_count + COUNT_W'(out_sum[DATA_W]);
         end
      end
   end
endmodule

// File: tb/tb_adder_txn_initiator.sv
// tb_adder_txn_initiator: two initiators (settle 1 / 16-bit counters, settle 3 / 2-bit
// counters) checked every cycle against a timestamp-based transaction model.
`timescale 1ns/1ps
module tb_adder_txn_initiator;
   logic clk = 0, rst_n = 0;
   logic iv [2], orr [2], rdy [2], ov [2], oc [2];
   logic [3:0] ia [2], ib [2], da [2], db [2];
   logic [4:0] rc [2], os [2];
   logic [15:0] tc0, cc0;
   logic [1:0] tc1, cc1;
   int nchk = 0, nerr = 0;

   // model state: a transaction accepted at edge acc becomes visible after edge acc+S
   int  S [2] = '{1, 3};
   int  msk [2] = '{65535, 3};
   bit  m_have [2];
   int  m_cyc [2], m_acc [2], m_txn [2], m_car [2];
   logic [3:0] m_a [2], m_b [2];
   logic [4:0] m_last [2];

   always #5 clk = ~clk;

   assign rc[0] = {1'b0, da[0]} + {1'b0, db[0]};
   assign rc[1] = {1'b0, da[1]} + {1'b0, db[1]};

   adder_txn_initiator u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_a(ia[0]), .in_b(ib[0]),
      .drv_a(da[0]), .drv_b(db[0]), .res_c(rc[0]), .out_valid(ov[0]), .out_ready(orr[0]),
      .out_sum(os[0]), .out_carry(oc[0]), .txn_count(tc0), .carry_count(cc0));

   adder_txn_initiator #(.DATA_W(4), .SETTLE_CYCLES(3), .COUNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_a(ia[1]), .in_b(ib[1]),
      .drv_a(da[1]), .drv_b(db[1]), .res_c(rc[1]), .out_valid(ov[1]), .out_ready(orr[1]),
      .out_sum(os[1]), .out_carry(oc[1]), .txn_count(tc1), .carry_count(cc1));

   function automatic logic [4:0] sum5(logic [3:0] a, logic [3:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic bit m_ov(int i);
      return m_have[i] && m_cyc[i] >= m_acc[i] + S[i];
   endfunction

   task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", n, i, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_have[i] = 0; m_cyc[i] = 0; m_acc[i] = 0; m_txn[i] = 0; m_car[i] = 0;
            m_a[i] = 0; m_b[i] = 0; m_last[i] = 0;
         end else begin
            bit o, r;
            o = m_ov(i);
            r = !m_have[i] || (o && orr[i]);
            if (o && orr[i]) begin
               m_last[i] = sum5(m_a[i], m_b[i]);
               m_txn[i] = (m_txn[i] + 1) & msk[i];
               if (m_last[i][4]) m_car[i] = (m_car[i] + 1) & msk[i];
               m_have[i] = 0;
            end
            m_cyc[i]++;
            if (iv[i] && r) begin
               m_have[i] = 1; m_acc[i] = m_cyc[i]; m_a[i] = ia[i]; m_b[i] = ib[i];
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
         logic [4:0] es;
         bit eo;
         eo = m_ov(i);
         es = eo ? sum5(m_a[i], m_b[i]) : m_last[i];
         chk("out_valid", i, ov[i], eo);
         chk("in_ready", i, rdy[i], !m_have[i] || (eo && orr[i]));
         chk("drv_a", i, da[i], m_a[i]);
         chk("drv_b", i, db[i], m_b[i]);
         chk("out_sum", i, os[i], es);
         chk("out_carry", i, oc[i], es[4]);
         chk("txn_count", i, i == 0 ? tc0 : {14'b0, tc1}, m_txn[i]);
         chk("carry_count", i, i == 0 ? cc0 : {14'b0, cc1}, m_car[i]);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic req(int i, logic [3:0] a, logic [3:0] b);
      int k = 0;
      @(negedge clk);
      iv[i] = 1; ia[i] = a; ib[i] = b;
      while (!rdy[i] && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("req_accept_in_time", i, k < 50, 1);
      @(posedge clk);
      #2;
      iv[i] = 0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         iv[i] = 0; ia[i] = 0; ib[i] = 0; orr[i] = 1;
      end
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 0, rdy[0], 1);
      chk("rst_out_valid", 0, ov[0], 0);
      chk("rst_txn", 0, tc0, 0);
      rst_n = 1;
      // basic sum
      req(0, 5, 5);
      chk("basic_drv_a", 0, da[0], 5);
      chk("basic_drv_b", 0, db[0], 5);
      chk("basic_not_valid", 0, ov[0], 0);
      @(posedge clk); #2;
      chk("basic_valid", 0, ov[0], 1);
      chk("basic_sum", 0, os[0], 10);
      chk("basic_carry", 0, oc[0], 0);
      @(posedge clk); #2;
      chk("basic_txn", 0, tc0, 1);
      chk("basic_carry_cnt", 0, cc0, 0);
      // carry out
      req(0, 15, 15);
      @(posedge clk); #2;
      chk("carry_sum", 0, os[0], 30);
      chk("carry_bit", 0, oc[0], 1);
      @(posedge clk); #2;
      chk("carry_cnt", 0, cc0, 1);
      chk("carry_txn", 0, tc0, 2);
      // backpressure with a waiting back-to-back request
      orr[0] = 0;
      req(0, 3, 9);
      iv[0] = 1; ia[0] = 1; ib[0] = 1;
      repeat (5) begin
         @(posedge clk); #2;
         chk("bp_valid", 0, ov[0], 1);
         chk("bp_sum_hold", 0, os[0], 12);
         chk("bp_not_ready", 0, rdy[0], 0);
         chk("bp_drv_a_hold", 0, da[0], 3);
      end
      @(negedge clk);
      orr[0] = 1;
      #1;
      chk("bp_ready_rises", 0, rdy[0], 1);
      @(posedge clk); #2;
      iv[0] = 0;
      chk("b2b_valid_falls", 0, ov[0], 0);
      chk("b2b_drv_a", 0, da[0], 1);
      chk("b2b_txn", 0, tc0, 3);
      @(posedge clk); #2;
      chk("b2b_valid", 0, ov[0], 1);
      chk("b2b_sum", 0, os[0], 2);
      @(posedge clk); #2;
      chk("b2b_txn2", 0, tc0, 4);
      // three-edge settle on the second instance
      req(1, 7, 8);
      chk("s3_drv_a", 1, da[1], 7);
      chk("s3_not_valid", 1, ov[1], 0);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #2;
         chk("s3_valid_edge", 1, ov[1], k == 3);
      end
      chk("s3_sum", 1, os[1], 15);
      @(posedge clk); #2;
      chk("s3_txn", 1, {14'b0, tc1}, 1);
      // reset during SETTLE
      req(0, 9, 9);
      #1;
      rst_n = 0;
      #1;
      chk("mid_rst_valid", 0, ov[0], 0);
      chk("mid_rst_drv_a", 0, da[0], 0);
      chk("mid_rst_drv_b", 0, db[0], 0);
      chk("mid_rst_txn", 0, tc0, 0);
      @(negedge clk);
      rst_n = 1;
      #1;
      chk("post_rst_ready", 0, rdy[0], 1);
      req(0, 2, 2);
      @(posedge clk); #2;
      chk("post_rst_valid", 0, ov[0], 1);
      chk("post_rst_sum", 0, os[0], 4);
      @(posedge clk); #2;
      // 2-bit counter wrap
      for (int t = 1; t <= 5; t++) begin
         req(1, 8, 8);
         repeat (4) @(posedge clk);
         #2;
         chk("wrap_txn", 1, {14'b0, tc1}, t % 4);
         chk("wrap_carry", 1, {14'b0, cc1}, t % 4);
      end
      // randomized traffic on both instances, with one reset in the middle
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n = !(c >= 1500 && c < 1502);
         for (int i = 0; i < 2; i++) begin
            iv[i]  = 1'($urandom_range(0, 1));
            ia[i]  = 4'($urandom);
            ib[i]  = 4'($urandom);
            orr[i] = $urandom_range(0, 3) != 0;
         end
      end
      @(negedge clk);
      iv[0] = 0; iv[1] = 0; orr[0] = 1; orr[1] = 1;
      repeat (8) @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/adder_txn_initiator.md
Name: adder_txn_initiator

Overview:
- Sequential initiator for the combinational adder interface (operand pair a/b in, sum c out).
- Accepts operand pairs on a valid/ready request channel and drives them onto the adder's a/b nets.
- Waits a fixed settle time, captures c, and returns the sum on a valid/ready response channel.
- Keeps transaction and carry-out counters for the verification scoreboard and for debug.

Parameters:
- DATA_W, 4, operand width. The sum width is DATA_W+1.
- SETTLE_CYCLES, 1, number of clock edges between driving a/b and capturing c. Must be at least 1; elaboration fails if it is 0.
- COUNT_W, 16, width of the transaction and carry counters.

Ports:
- clk  input  1  single clock for all logic; rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  request ready.
- in_a  input  DATA_W  operand a.
- in_b  input  DATA_W  operand b.
- drv_a  output  DATA_W  registered operand driven to the adder's a.
- drv_b  output  DATA_W  registered operand driven to the adder's b.
- res_c  input  DATA_W+1  adder sum c, combinational from drv_a/drv_b.
- out_valid  output  1  response valid.
- out_ready  input  1  response ready.
- out_sum  output  DATA_W+1  captured sum.
- out_carry  output  1  equal to out_sum[DATA_W].
- txn_count  output  COUNT_W  count of completed response handshakes.
- carry_count  output  COUNT_W  count of completed responses with carry set.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. drv_a, drv_b, out_sum, txn_count and carry_count are 0. out_valid is 0. in_ready is 1 once in IDLE.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: register in_a/in_b into drv_a/drv_b, load the settle counter with SETTLE_CYCLES, go to SETTLE.
- State SETTLE:
  - in_ready = 0 and out_valid = 0. in_valid is ignored.
  - The counter decrements each edge.
  - On the edge where the counter reaches 1: register res_c into out_sum, go to RESP.
- State RESP:
  - out_valid = 1. out_sum and out_carry hold stable until the handshake.
  - On out_valid & out_ready: increment txn_count. If out_carry = 1, also increment carry_count.
  - Back-to-back case (in_valid = 1 in the same cycle): treat it as an IDLE acceptance (new drv_a/drv_b, go to SETTLE, out_valid falls next cycle).
  - Otherwise go to IDLE.
- in_ready is combinational: IDLE, or (RESP & out_ready).
- Latency: request accepted at edge N → drv_a/drv_b valid after edge N → out_sum captured at edge N+SETTLE_CYCLES → out_valid high from then. Minimum request-to-request spacing is SETTLE_CYCLES+1 cycles.
- drv_a/drv_b hold the last operands after a transaction completes; they are not cleared.
- Width rules: out_sum is res_c captured unmodified (DATA_W+1 bits). Counters wrap from all-ones to 0, with no saturation or flag.
- out_ready high while out_valid is low has no effect.
- Reset asserted mid-SETTLE or mid-RESP: the in-flight transaction is dropped, with no response and no count increment. All outputs return to reset values immediately.

Test Plan:
- DATA_W=4, SETTLE_CYCLES=1, basic sum:
  - Send a=5, b=5 with out_ready=1.
  - Required: drv_a=5, drv_b=5 one edge after accept; out_valid one edge later with out_sum=10, out_carry=0; txn_count=1, carry_count=0.
- Carry out:
  - Send a=15, b=15.
  - Required: out_sum=30 (5'b11110), out_carry=1; carry_count=1 after the handshake.
- Backpressure:
  - Send a=3, b=9 with out_ready=0 for 5 cycles, while in_valid stays high with a=1, b=1.
  - Required: out_sum holds 12, in_ready stays 0, the second request is not accepted until out_ready rises.
  - Required: the back-to-back accept on that cycle, then out_sum=2.
- SETTLE_CYCLES=3 latency:
  - Send a=7, b=8.
  - Required: out_valid rises exactly 3 edges after drv_a=7 appears; out_sum=15.
- Reset mid-operation:
  - Accept a=9, b=9, then drop rst_n during SETTLE.
  - Required: out_valid=0, drv_a=0, drv_b=0 and txn_count=0 immediately; after release, in_ready=1 and a new 2+2 gives out_sum=4.
- Counter wrap with COUNT_W=2:
  - Run 5 transactions of 8+8.
  - Required: txn_count sequence 1,2,3,0,1; carry_count follows the same sequence.
